// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch front end. Issues in-order instruction memory requests starting at
//   PC_BASE_ADDRESS, tags returned words with their fetch PC and buffers them
//   for decode behind a valid/ready handshake. A redirect restarts fetch at a
//   new word-aligned address and abandons all work in flight.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   enable                          allow new fetch requests
//   redirect_valid, redirect_pc     restart fetch at redirect_pc (bits [1:0] ignored)
//   imem_req_valid/addr/ready       request channel to instruction memory
//   imem_resp_valid/data            in-order response channel from memory
//   inst_valid/ready/data/pc        instruction stream to decode
//   fetch_pc                        next address to be requested
//
// state | meaning
// IDLE  | out of reset, no requests until enable is seen
// RUN   | issuing requests while in-flight + buffered < FIFO_DEPTH
// DRAIN | after a redirect, dropping responses to abandoned requests

module instr_fetch_unit #(
  parameter int                     WORD_LENGTH     = 32,
  parameter logic [WORD_LENGTH-1:0] PC_BASE_ADDRESS = 'h40_0000,
  parameter int                     FIFO_DEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   redirect_valid,
  input  logic [WORD_LENGTH-1:0] redirect_pc,
  output logic                   imem_req_valid,
  output logic [WORD_LENGTH-1:0] imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_resp_valid,
  input  logic [WORD_LENGTH-1:0] imem_resp_data,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [WORD_LENGTH-1:0] inst_data,
  output logic [WORD_LENGTH-1:0] inst_pc,
  output logic [WORD_LENGTH-1:0] fetch_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]             state;
  logic [WORD_LENGTH-1:0] pc_q;
  logic [CW-1:0]          outstanding;   // all requests in flight, including abandoned ones
  logic [CW-1:0]          discard;       // abandoned requests still to come back
  logic [CW-1:0]          fifo_count;

  // PCs of live requests in flight, oldest at pcq_rd
  logic [WORD_LENGTH-1:0] pcq_mem [FIFO_DEPTH];
  logic [PW-1:0]          pcq_wr, pcq_rd;

  logic [WORD_LENGTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [WORD_LENGTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]          fifo_wr, fifo_rd;

  logic [CW:0]            credit_used;
  logic                   req_fire, resp_take, resp_drop, resp_keep, inst_pop;
  logic [CW-1:0]          discard_redirect, discard_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit covers both in-flight requests and buffered words, so a response
  // always has a FIFO slot waiting for it.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = (state == RUN) & enable & ~redirect_valid & (credit_used < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign fetch_pc       = pc_q;

  assign req_fire  = imem_req_valid & imem_req_ready;
  assign resp_take = imem_resp_valid & (outstanding != '0);
  assign resp_drop = resp_take & (discard != '0);
  assign resp_keep = resp_take & (discard == '0);

  assign inst_valid = (fifo_count != '0);
  assign inst_data  = fifo_data[fifo_rd];
  assign inst_pc    = fifo_pc[fifo_rd];
  assign inst_pop   = inst_valid & inst_ready;

  // A response arriving with the redirect is itself dropped, so it leaves the count now.
  assign discard_redirect = outstanding - CW'(resp_take);
  assign discard_next     = discard - CW'(resp_drop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc_q        <= PC_BASE_ADDRESS;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pcq_mem[i]   <= '0;
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ~WORD_LENGTH'(3);
      if (state != IDLE) begin
        outstanding <= discard_redirect;
        discard     <= discard_redirect;
        fifo_count  <= '0;
        pcq_wr      <= '0;
        pcq_rd      <= '0;
        fifo_wr     <= '0;
        fifo_rd     <= '0;
        state       <= (discard_redirect != '0) ? DRAIN : RUN;
      end
    end else begin
      if (req_fire) begin
        pcq_mem[pcq_wr] <= pc_q;
        pcq_wr          <= ptr_inc(pcq_wr);
        pc_q            <= pc_q + WORD_LENGTH'(4);
      end
      if (resp_keep) begin
        fifo_pc[fifo_wr]   <= pcq_mem[pcq_rd];
        fifo_data[fifo_wr] <= imem_resp_data;
        pcq_rd             <= ptr_inc(pcq_rd);
        fifo_wr            <= ptr_inc(fifo_wr);
      end
      if (inst_pop) fifo_rd <= ptr_inc(fifo_rd);
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
      discard     <= discard_next;
      fifo_count  <= fifo_count + CW'(resp_keep) - CW'(inst_pop);
      case (state)
        IDLE:    if (enable) state <= RUN;
        DRAIN:   if (discard_next == '0) state <= RUN;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset, enable, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc, fetch_pc;

  instr_fetch_unit #(.WORD_LENGTH(32), .PC_BASE_ADDRESS(32'h0040_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] pc; bit dead; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;

  // reference model: requests in flight (oldest first) and words awaiting decode
  flight_t     m_fl[$];
  entry_t      m_buf[$];
  logic [31:0] m_pc;
  bit          m_started;
  bit          model_on = 0;

  logic [31:0] mem_q[$];
  bit          mem_hold = 0;
  logic [31:0] req_log[$];
  entry_t      del_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_req(input string name, input int idx, input logic [31:0] exp);
    if (idx < req_log.size()) chk(name, req_log[idx], exp);
    else begin
      checks++; errors++;
      $display("FAIL %s request %0d missing, required=%h", name, idx, exp);
    end
  endtask

  task automatic chk_del(input string name, input int idx, input logic [31:0] pc, input logic [31:0] data);
    if (idx < del_log.size()) begin
      chk({name, "_pc"}, del_log[idx].pc, pc);
      chk({name, "_data"}, del_log[idx].data, data);
    end else begin
      checks++; errors++;
      $display("FAIL %s delivery %0d missing, required pc=%h", name, idx, pc);
    end
  endtask

  // compare, then advance the model to what the next posedge must produce
  always @(negedge clk) begin
    int dead;
    bit exp_req;
    bit resp;
    flight_t f;
    entry_t  e;
    dead = 0;
    foreach (m_fl[i]) if (m_fl[i].dead) dead++;
    exp_req = m_started && enable && !redirect_valid && dead == 0 &&
              (m_fl.size() + m_buf.size() < DEPTH);
    if (model_on) begin
      chk("req_valid", imem_req_valid, exp_req);
      if (exp_req) chk("req_addr", imem_req_addr, m_pc);
      chk("fetch_pc", fetch_pc, m_pc);
      chk("inst_valid", inst_valid, m_buf.size() != 0);
      if (m_buf.size() != 0 && inst_valid) begin
        chk("inst_pc", inst_pc, m_buf[0].pc);
        chk("inst_data", inst_data, m_buf[0].data);
      end
    end
    if (!reset && imem_req_valid && imem_req_ready) begin
      req_log.push_back(imem_req_addr);
      mem_q.push_back(imem_req_addr);
    end
    if (!reset && !redirect_valid && inst_valid && inst_ready)
      del_log.push_back('{pc: inst_pc, data: inst_data});

    if (reset) begin
      m_fl.delete(); m_buf.delete();
      m_pc = BASE; m_started = 0; model_on = 1;
    end else begin
      resp = imem_resp_valid && m_fl.size() > 0;
      if (redirect_valid) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        if (resp) void'(m_fl.pop_front());
        foreach (m_fl[i]) m_fl[i].dead = 1;
        m_buf.delete();
      end else begin
        if (inst_ready && m_buf.size() != 0) void'(m_buf.pop_front());
        if (resp) begin
          f = m_fl.pop_front();
          if (!f.dead) begin
            e.pc = f.pc; e.data = imem_resp_data;
            m_buf.push_back(e);
          end
        end
        if (exp_req && imem_req_ready) begin
          m_fl.push_back('{pc: m_pc, dead: 0});
          m_pc = m_pc + 32'd4;
        end
        if (enable) m_started = 1;
      end
    end
  end

  // memory: answers accepted requests in order, one cycle later, unless held
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!mem_hold && mem_q.size() > 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_q.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    enable = 0; redirect_valid = 0; mem_hold = 0; inst_ready = 1; imem_req_ready = 1;
    cyc(6);
    reset = 1;
    cyc(1);
    reset = 0;
    req_log.delete(); del_log.delete();
  endtask

  task automatic two_in_flight();
    quiesce();
    inst_ready = 0; mem_hold = 1; enable = 1;
    cyc(5);
  endtask

  initial begin
    int bad;
    reset = 1; enable = 0; redirect_valid = 0; redirect_pc = '0;
    imem_req_ready = 1; inst_ready = 1;
    cyc(2);
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_inst_valid", inst_valid, 0);
    chk("reset_inst_data", inst_data, 0);
    chk("reset_inst_pc", inst_pc, 0);
    chk("reset_fetch_pc", fetch_pc, 32'h0040_0000);
    chk("mem_word_pin", mem_word(32'h0040_0000), 32'h5A1A_1357);
    reset = 0;
    cyc(1);

    // streaming
    quiesce();
    enable = 1;
    cyc(12);
    chk_req("t1_req0", 0, 32'h0040_0000);
    chk_req("t1_req1", 1, 32'h0040_0004);
    chk_req("t1_req2", 2, 32'h0040_0008);
    chk_del("t1_del0", 0, 32'h0040_0000, 32'h5A1A_1357);
    chk_del("t1_del1", 1, 32'h0040_0004, 32'h5A1A_135B);
    chk_del("t1_del2", 2, 32'h0040_0008, 32'h5A1A_135F);

    // decode stall
    quiesce();
    inst_ready = 0; enable = 1;
    cyc(10);
    chk("t2_req_count", req_log.size(), 2);
    chk("t2_req_stopped", imem_req_valid, 0);
    chk("t2_hold_pc", inst_pc, 32'h0040_0000);
    chk("t2_hold_data", inst_data, 32'h5A1A_1357);
    inst_ready = 1;
    cyc(12);
    chk_del("t2_del0", 0, 32'h0040_0000, 32'h5A1A_1357);
    chk_del("t2_del1", 1, 32'h0040_0004, 32'h5A1A_135B);
    chk_req("t2_resume", 2, 32'h0040_0008);
    bad = 0;
    foreach (del_log[i]) if (del_log[i].pc !== BASE + 32'(4 * i)) bad++;
    chk("t2_no_loss_dup", bad, 0);

    // redirect with two requests in flight
    two_in_flight();
    chk("t3_inflight", req_log.size(), 2);
    redirect_valid = 1; redirect_pc = 32'h0040_0100;
    cyc(1);
    redirect_valid = 0; mem_hold = 0; inst_ready = 1;
    chk("t3_drain_noreq", imem_req_valid, 0);
    cyc(10);
    chk_req("t3_next_req", 2, 32'h0040_0100);
    chk_del("t3_first", 0, 32'h0040_0100, 32'h5A1A_1457);

    // unaligned redirect coinciding with a response
    two_in_flight();
    mem_hold = 0; inst_ready = 1; redirect_valid = 1; redirect_pc = 32'h0040_0103;
    cyc(1);
    redirect_valid = 0;
    cyc(10);
    chk_req("t4_aligned_req", 2, 32'h0040_0100);
    chk_del("t4_first", 0, 32'h0040_0100, 32'h5A1A_1457);

    // reset with a full buffer
    quiesce();
    enable = 1; inst_ready = 0;
    cyc(8);
    chk("t5_full", inst_valid, 1);
    reset = 1;
    cyc(1);
    reset = 0; enable = 0;
    chk("t5_full_flushed", inst_valid, 0);
    chk("t5_full_pc", fetch_pc, 32'h0040_0000);

    // reset with requests in flight; their responses must be ignored
    two_in_flight();
    reset = 1; mem_hold = 0;
    cyc(1);
    reset = 0; enable = 0; inst_ready = 1;
    chk("t5_flight_flushed", inst_valid, 0);
    chk("t5_flight_pc", fetch_pc, 32'h0040_0000);
    cyc(4);
    chk("t5_stale_ignored", inst_valid, 0);
    enable = 1;
    req_log.delete(); del_log.delete();
    cyc(8);
    chk_del("t5_restart", 0, 32'h0040_0000, 32'h5A1A_1357);

    // address wrap and request held under back-pressure
    quiesce();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    cyc(1);
    redirect_valid = 0;
    chk("t6_idle_redirect", fetch_pc, 32'hFFFF_FFFC);
    imem_req_ready = 0; enable = 1;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_hold_valid", imem_req_valid, 1);
      chk("t6_hold_addr", imem_req_addr, 32'hFFFF_FFFC);
      cyc(1);
    end
    imem_req_ready = 1;
    req_log.delete(); del_log.delete();
    cyc(8);
    chk_req("t6_req0", 0, 32'hFFFF_FFFC);
    chk_req("t6_req1", 1, 32'h0000_0000);
    chk_del("t6_del0", 0, 32'hFFFF_FFFC, 32'hA5A6_1353);
    chk_del("t6_del1", 1, 32'h0000_0000, 32'h5A5A_1357);

    enable = 0;
    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
